// File: rtl/freq_counter_mc.sv
// freq_counter_mc: multi-channel reciprocal frequency counter, Wishbone classic slave.
// Each channel counts clk_i cycles between a reference rising edge of its input
// and the EDGES-th rising edge after it; software computes f = EDGES * f_clk / COUNT.
// Optional macro FREQ_CNT_IRQ_EN adds the irq_o port and the IRQ_MASK register.
module freq_counter_mc #(
  parameter int          NUM_CH      = 4,
  parameter int          CNT_W       = 32,
  parameter int          EDGE_W      = 16,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h8
) (
  input  logic              clk_i,
  input  logic              ext_rst_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       dat_i,
  input  logic              we_i,
  input  logic [3:0]        sel_i,
  input  logic              cyc_i,
  input  logic              stb_i,
  output logic [31:0]       dat_o,
  output logic              ack_o,
  output logic              err_o,
  input  logic [NUM_CH-1:0] sig_i,
  output logic [NUM_CH-1:0] busy_o,
  output logic [NUM_CH-1:0] done_o
`ifdef FREQ_CNT_IRQ_EN
  ,
  output logic              irq_o
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_MEAS = 2'd2,
    ST_DONE = 2'd3
  } ch_state_t;

  // Offsets: CTRL, STATUS, EDGES, TIMEOUT, then one COUNT per channel.
  localparam logic [31:0] OFF_CTRL  = 32'd0;
  localparam logic [31:0] OFF_STAT  = 32'd1;
  localparam logic [31:0] OFF_EDGE  = 32'd2;
  localparam logic [31:0] OFF_TMO   = 32'd3;
  localparam logic [31:0] OFF_CNT0  = 32'd4;
`ifdef FREQ_CNT_IRQ_EN
  localparam logic [31:0] OFF_MASK  = 32'(4 + NUM_CH);
`endif

  // ------------------------------------------------------------------
  // Bus decode
  // ------------------------------------------------------------------
  logic              ack_q, err_q;
  logic [31:0]       dat_q;
  logic [31:0]       off;
  logic              access, wr_en;
  logic              reg_hit;
  logic [31:0]       rd_data;

  logic [EDGE_W-1:0] edges_q;
  logic [CNT_W-1:0]  timeout_q;
`ifdef FREQ_CNT_IRQ_EN
  logic [NUM_CH-1:0] mask_q;
  logic              irq_q;
`endif

  logic [NUM_CH-1:0] start_vec;
  logic              abort;
  logic [NUM_CH-1:0] clr_done, clr_tmo;
  logic [NUM_CH-1:0] done_vec, tmo_vec, busy_vec;
  logic [CNT_W-1:0]  count_arr [NUM_CH];

  // An access is accepted only when no ack/err is pending, so a master holding
  // stb through the ack cycle is not served twice.
  assign off    = addr_i - BASE_ADDR;
  assign access = cyc_i & stb_i & ~ack_q & ~err_q;
  assign wr_en  = access & we_i & (sel_i == 4'hF);

  assign start_vec = (wr_en && off == OFF_CTRL) ? dat_i[NUM_CH-1:0] : '0;
  assign abort     = wr_en && (off == OFF_CTRL) && dat_i[31];
  assign clr_done  = (wr_en && off == OFF_STAT) ? dat_i[NUM_CH-1:0] : '0;
  assign clr_tmo   = (wr_en && off == OFF_STAT) ? dat_i[16 +: NUM_CH] : '0;

  // Read mux and address map hit detection
  always_comb begin
    rd_data = '0;
    reg_hit = 1'b0;
    if (off == OFF_CTRL) begin
      reg_hit = 1'b1;
    end else if (off == OFF_STAT) begin
      reg_hit = 1'b1;
      rd_data[NUM_CH-1:0]  = done_vec;
      rd_data[16 +: NUM_CH] = tmo_vec;
    end else if (off == OFF_EDGE) begin
      reg_hit = 1'b1;
      rd_data[EDGE_W-1:0] = edges_q;
    end else if (off == OFF_TMO) begin
      reg_hit = 1'b1;
      rd_data[CNT_W-1:0] = timeout_q;
    end
`ifdef FREQ_CNT_IRQ_EN
    else if (off == OFF_MASK) begin
      reg_hit = 1'b1;
      rd_data[NUM_CH-1:0] = mask_q;
    end
`endif
    for (int k = 0; k < NUM_CH; k++) begin
      if (off == OFF_CNT0 + 32'(k)) begin
        reg_hit = 1'b1;
        rd_data[CNT_W-1:0] = count_arr[k];
      end
    end
  end

  // Bus handshake: one-cycle ack or err per accepted access, registered read data
  always_ff @(posedge clk_i or negedge ext_rst_i) begin
    if (!ext_rst_i) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= access & reg_hit;
      err_q <= access & ~reg_hit;
      dat_q <= (access & reg_hit & ~we_i) ? rd_data : '0;
    end
  end

  assign ack_o = ack_q;
  assign err_o = err_q;
  assign dat_o = dat_q;

  // Configuration registers; an EDGES value of 0 would never complete, so it becomes 1
  always_ff @(posedge clk_i or negedge ext_rst_i) begin
    if (!ext_rst_i) begin
      edges_q   <= EDGE_W'(1);
      timeout_q <= '0;
`ifdef FREQ_CNT_IRQ_EN
      mask_q    <= '0;
`endif
    end else if (wr_en) begin
      if (off == OFF_EDGE) begin
        edges_q <= (dat_i[EDGE_W-1:0] == '0) ? EDGE_W'(1) : dat_i[EDGE_W-1:0];
      end
      if (off == OFF_TMO) begin
        timeout_q <= dat_i[CNT_W-1:0];
      end
`ifdef FREQ_CNT_IRQ_EN
      if (off == OFF_MASK) begin
        mask_q <= dat_i[NUM_CH-1:0];
      end
`endif
    end
  end

`ifdef FREQ_CNT_IRQ_EN
  // Level interrupt from masked done/timeout flags; cleared through STATUS
  always_ff @(posedge clk_i or negedge ext_rst_i) begin
    if (!ext_rst_i) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |((done_vec | tmo_vec) & mask_q);
    end
  end
  assign irq_o = irq_q;
`endif

  assign busy_o = busy_vec;
  assign done_o = done_vec;

  // ------------------------------------------------------------------
  // Per-channel measurement engines
  // ------------------------------------------------------------------
  genvar gi;
  for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_dly_q;
    logic                   rise;
    ch_state_t              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       tmo_cnt_q, tmo_cnt_d;
    logic [CNT_W-1:0]       tmo_tgt_q, tmo_tgt_d;
    logic [EDGE_W-1:0]      edge_cnt_q, edge_cnt_d;
    logic [EDGE_W-1:0]      edge_tgt_q, edge_tgt_d;
    logic                   done_q, done_d;
    logic                   tmo_q, tmo_d;
    logic                   restart_q, restart_d;
    logic                   tmo_hit, last_edge;

    // Synchroniser chain plus one delay flop for rising-edge detection
    always_ff @(posedge clk_i or negedge ext_rst_i) begin
      if (!ext_rst_i) begin
        sync_q     <= '0;
        sync_dly_q <= 1'b0;
      end else begin
        sync_q     <= {sync_q[SYNC_STAGES-2:0], sig_i[gi]};
        sync_dly_q <= sync_q[SYNC_STAGES-1];
      end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~sync_dly_q;

    // Timeout fires on the TIMEOUT-th cycle spent in ARM/MEAS since the start.
    assign tmo_hit = (tmo_tgt_q != '0) &&
                     (({1'b0, tmo_cnt_q} + (CNT_W+1)'(1)) >= {1'b0, tmo_tgt_q});
    // The arming edge is the reference; the EDGES-th edge after it completes.
    assign last_edge = rise && ((edge_cnt_q + EDGE_W'(1)) == edge_tgt_q);

    // Channel state register and measurement counters
    always_ff @(posedge clk_i or negedge ext_rst_i) begin
      if (!ext_rst_i) begin
        state_q    <= ST_IDLE;
        cnt_q      <= '0;
        tmo_cnt_q  <= '0;
        tmo_tgt_q  <= '0;
        edge_cnt_q <= '0;
        edge_tgt_q <= EDGE_W'(1);
        done_q     <= 1'b0;
        tmo_q      <= 1'b0;
        restart_q  <= 1'b0;
      end else begin
        state_q    <= state_d;
        cnt_q      <= cnt_d;
        tmo_cnt_q  <= tmo_cnt_d;
        tmo_tgt_q  <= tmo_tgt_d;
        edge_cnt_q <= edge_cnt_d;
        edge_tgt_q <= edge_tgt_d;
        done_q     <= done_d;
        tmo_q      <= tmo_d;
        restart_q  <= restart_d;
      end
    end

    // Next-state logic: flag sets are applied after W1C clears so a set wins
    always_comb begin
      logic go_arm;
      state_d    = state_q;
      cnt_d      = cnt_q;
      tmo_cnt_d  = tmo_cnt_q;
      tmo_tgt_d  = tmo_tgt_q;
      edge_cnt_d = edge_cnt_q;
      edge_tgt_d = edge_tgt_q;
      done_d     = done_q & ~clr_done[gi];
      tmo_d      = tmo_q & ~clr_tmo[gi];
      restart_d  = 1'b0;
      go_arm     = 1'b0;

      if (abort) begin
        state_d = ST_IDLE;
        done_d  = 1'b0;
        tmo_d   = 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start_vec[gi] || restart_q) go_arm = 1'b1;
          end
          ST_ARM, ST_MEAS: begin
            if (start_vec[gi]) begin
              // Restart while busy: drop to IDLE now, re-arm on the next cycle
              state_d   = ST_IDLE;
              restart_d = 1'b1;
              done_d    = 1'b0;
              tmo_d     = 1'b0;
            end else begin
              tmo_cnt_d = (tmo_cnt_q == '1) ? tmo_cnt_q : tmo_cnt_q + CNT_W'(1);
              if (state_q == ST_ARM && rise) begin
                state_d = ST_MEAS;
                cnt_d   = CNT_W'(1);
              end else if (state_q == ST_MEAS && last_edge) begin
                // Count holds: it already equals period * EDGES
                state_d    = ST_DONE;
                edge_cnt_d = edge_cnt_q + EDGE_W'(1);
                done_d     = 1'b1;
              end else if (tmo_hit) begin
                state_d = ST_IDLE;
                cnt_d   = '1;
                tmo_d   = 1'b1;
                done_d  = 1'b0;
              end else if (state_q == ST_MEAS) begin
                cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
                if (rise) edge_cnt_d = edge_cnt_q + EDGE_W'(1);
              end
            end
          end
          ST_DONE: begin
            if (start_vec[gi]) go_arm = 1'b1;
          end
          default: state_d = ST_IDLE;
        endcase
      end

      if (go_arm) begin
        state_d    = ST_ARM;
        cnt_d      = '0;
        edge_cnt_d = '0;
        tmo_cnt_d  = '0;
        done_d     = 1'b0;
        tmo_d      = 1'b0;
        edge_tgt_d = edges_q;
        tmo_tgt_d  = timeout_q;
      end
    end

    assign busy_vec[gi]  = (state_q == ST_ARM) || (state_q == ST_MEAS);
    assign done_vec[gi]  = done_q;
    assign tmo_vec[gi]   = tmo_q;
    assign count_arr[gi] = cnt_q;
  end

endmodule

// File: tb/tb_freq_counter_mc.sv
// Testbench for freq_counter_mc: scoreboard of expected register reads,
// one task per scenario, periodic square waves on each channel.
module tb_freq_counter_mc;

  localparam logic [31:0] A_CTRL = 32'h8;
  localparam logic [31:0] A_STAT = 32'h9;
  localparam logic [31:0] A_EDGE = 32'hA;
  localparam logic [31:0] A_TMO  = 32'hB;
  localparam logic [31:0] A_CNT0 = 32'hC;

  logic        clk_i = 1'b0;
  logic        ext_rst_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] dat_i = '0;
  logic        we_i = 1'b0;
  logic [3:0]  sel_i = 4'h0;
  logic        cyc_i = 1'b0;
  logic        stb_i = 1'b0;
  logic [31:0] dat_o;
  logic        ack_o, err_o;
  logic [3:0]  sig_i = 4'h0;
  logic [3:0]  busy_o, done_o;

  int total = 0;
  int bad = 0;

  logic [31:0] exp_d [$];
  logic        exp_e [$];
  logic [31:0] rd, ed;
  logic        ak, er, ee;

  int per [4] = '{default: 0};
  int ph  [4] = '{default: 0};

  freq_counter_mc dut (
    .clk_i(clk_i), .ext_rst_i(ext_rst_i), .addr_i(addr_i), .dat_i(dat_i),
    .we_i(we_i), .sel_i(sel_i), .cyc_i(cyc_i), .stb_i(stb_i),
    .dat_o(dat_o), .ack_o(ack_o), .err_o(err_o),
    .sig_i(sig_i), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  // Square-wave generators: period per[k] clocks, rising edges exactly per[k] apart
  always @(posedge clk_i) begin
    for (int k = 0; k < 4; k++) begin
      if (per[k] == 0) begin
        sig_i[k] <= 1'b0;
        ph[k]    <= 0;
      end else begin
        sig_i[k] <= (ph[k] < per[k] / 2);
        ph[k]    <= (ph[k] + 1 >= per[k]) ? 0 : ph[k] + 1;
      end
    end
  end

  task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic w,
                     input logic [3:0] s);
    @(posedge clk_i); #1;
    addr_i = a; dat_i = d; we_i = w; sel_i = s; cyc_i = 1'b1; stb_i = 1'b1;
    ak = 1'b0; er = 1'b0; rd = '0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk_i); #1;
      if (ack_o || err_o) begin
        ak = ack_o; er = err_o; rd = dat_o;
        break;
      end
    end
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    if (!(ak || er)) begin
      total++; bad++;
      $display("FAIL bus_no_response addr=%h got ack=0 err=0 want a response", a);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus(a, d, 1'b1, 4'hF);
  endtask

  task automatic rdreg(input logic [31:0] a);
    bus(a, 32'h0, 1'b0, 4'hF);
  endtask

  task automatic test_reset();
    per[0] = 10;
    repeat (3) @(posedge clk_i);
    #1 ext_rst_i = 1'b1;
    wr(A_EDGE, 32'd4);
    wr(A_CTRL, 32'h1);
    repeat (20) @(posedge clk_i);
    #1 ext_rst_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    total++;
    if (busy_o !== 4'h0 || done_o !== 4'h0) begin
      bad++; $display("FAIL reset_busy_done got busy=%h done=%h want 0 0", busy_o, done_o);
    end
    ext_rst_i = 1'b1;
    @(posedge clk_i); #1;
    total++;
    if (ack_o !== 1'b0 || err_o !== 1'b0 || dat_o !== 32'h0 || busy_o !== 4'h0) begin
      bad++; $display("FAIL reset_outputs got ack=%b err=%b dat=%h busy=%h want all 0",
                      ack_o, err_o, dat_o, busy_o);
    end
    exp_d.push_back(32'd1); rdreg(A_EDGE); ed = exp_d.pop_front();
    total++;
    if (rd !== ed || ak !== 1'b1) begin
      bad++; $display("FAIL reset_edges got %h ack=%b want %h", rd, ak, ed);
    end
    exp_d.push_back(32'd0); rdreg(A_CNT0); ed = exp_d.pop_front();
    total++;
    if (rd !== ed || ak !== 1'b1) begin
      bad++; $display("FAIL reset_count0 got %h want %h", rd, ed);
    end
    exp_d.push_back(32'd0); rdreg(A_STAT); ed = exp_d.pop_front();
    total++;
    if (rd !== ed) begin
      bad++; $display("FAIL reset_status got %h want %h", rd, ed);
    end
  endtask

  task automatic test_single();
    int n;
    logic gap;
    per[0] = 10;
    wr(A_EDGE, 32'd4);
    wr(A_CTRL, 32'h1);
    n = 0; gap = 1'b0;
    while (done_o[0] !== 1'b1 && n < 300) begin
      if (busy_o[0] !== 1'b1) gap = 1'b1;
      @(posedge clk_i); #1; n++;
    end
    total++;
    if (done_o[0] !== 1'b1) begin
      bad++; $display("FAIL single_done got done0=%b want 1 within 300 cycles", done_o[0]);
    end
    total++;
    if (gap) begin
      bad++; $display("FAIL single_busy got busy0 low before done want continuous 1");
    end
    total++;
    if (busy_o[0] !== 1'b0) begin
      bad++; $display("FAIL single_busy_end got busy0=%b want 0", busy_o[0]);
    end
    exp_d.push_back(32'd40); rdreg(A_CNT0); ed = exp_d.pop_front();
    total++;
    if (rd !== ed || ak !== 1'b1) begin
      bad++; $display("FAIL single_count0 got %0d want %0d", rd, ed);
    end
    exp_d.push_back(32'h1); rdreg(A_STAT); ed = exp_d.pop_front();
    total++;
    if (rd !== ed) begin
      bad++; $display("FAIL single_status got %h want %h", rd, ed);
    end
    wr(A_STAT, 32'h1);
    exp_d.push_back(32'h0); rdreg(A_STAT); ed = exp_d.pop_front();
    total++;
    if (rd !== ed || done_o[0] !== 1'b0) begin
      bad++; $display("FAIL single_w1c got status=%h done0=%b want %h 0", rd, done_o[0], ed);
    end
  endtask

  task automatic test_concurrent();
    int n, t1, t2;
    per[1] = 7; per[2] = 13;
    wr(A_EDGE, 32'd3);
    wr(A_CTRL, 32'h6);
    n = 0; t1 = -1; t2 = -1;
    while ((t1 < 0 || t2 < 0) && n < 400) begin
      @(posedge clk_i); #1; n++;
      if (t1 < 0 && done_o[1] === 1'b1) t1 = n;
      if (t2 < 0 && done_o[2] === 1'b1) t2 = n;
    end
    total++;
    if (t1 < 0 || t2 < 0 || t1 >= t2) begin
      bad++; $display("FAIL conc_timing got t1=%0d t2=%0d want both done with t1<t2", t1, t2);
    end
    exp_d.push_back(32'd21); rdreg(A_CNT0 + 32'd1); ed = exp_d.pop_front();
    total++;
    if (rd !== ed) begin
      bad++; $display("FAIL conc_count1 got %0d want %0d", rd, ed);
    end
    exp_d.push_back(32'd39); rdreg(A_CNT0 + 32'd2); ed = exp_d.pop_front();
    total++;
    if (rd !== ed) begin
      bad++; $display("FAIL conc_count2 got %0d want %0d", rd, ed);
    end
    wr(A_STAT, 32'h6);
  endtask

  task automatic test_timeout();
    int n;
    per[3] = 0;
    wr(A_TMO, 32'd100);
    wr(A_CTRL, 32'h8);
    n = 0;
    while (busy_o[3] === 1'b1 && n < 200) begin
      @(posedge clk_i); #1; n++;
    end
    total++;
    if (n != 100) begin
      bad++; $display("FAIL tmo_cycles got %0d want 100", n);
    end
    total++;
    if (done_o[3] !== 1'b0) begin
      bad++; $display("FAIL tmo_done got done3=%b want 0", done_o[3]);
    end
    exp_d.push_back(32'h0008_0000); rdreg(A_STAT); ed = exp_d.pop_front();
    total++;
    if (rd !== ed) begin
      bad++; $display("FAIL tmo_status got %h want %h", rd, ed);
    end
    exp_d.push_back(32'hFFFF_FFFF); rdreg(A_CNT0 + 32'd3); ed = exp_d.pop_front();
    total++;
    if (rd !== ed) begin
      bad++; $display("FAIL tmo_count3 got %h want %h", rd, ed);
    end
    wr(A_TMO, 32'd0);
    wr(A_STAT, 32'h0008_0000);
    exp_d.push_back(32'h0); rdreg(A_STAT); ed = exp_d.pop_front();
    total++;
    if (rd !== ed) begin
      bad++; $display("FAIL tmo_w1c got %h want %h", rd, ed);
    end
  endtask

  task automatic test_restart();
    int n;
    per[0] = 10;
    wr(A_EDGE, 32'd4);
    wr(A_CTRL, 32'h1);
    repeat (25) @(posedge clk_i);
    wr(A_CTRL, 32'h1);
    wr(A_EDGE, 32'd2);
    n = 0;
    while (done_o[0] !== 1'b1 && n < 300) begin
      @(posedge clk_i); #1; n++;
    end
    total++;
    if (done_o[0] !== 1'b1) begin
      bad++; $display("FAIL restart_done got done0=%b want 1", done_o[0]);
    end
    exp_d.push_back(32'd40); rdreg(A_CNT0); ed = exp_d.pop_front();
    total++;
    if (rd !== ed) begin
      bad++; $display("FAIL restart_count0 got %0d want %0d", rd, ed);
    end
  endtask

  task automatic test_abort();
    per[1] = 7;
    wr(A_CTRL, 32'h2);
    repeat (5) @(posedge clk_i);
    #1;
    total++;
    if (busy_o[1] !== 1'b1) begin
      bad++; $display("FAIL abort_pre got busy1=%b want 1", busy_o[1]);
    end
    wr(A_CTRL, 32'h8000_0000);
    total++;
    if (busy_o !== 4'h0 || done_o !== 4'h0) begin
      bad++; $display("FAIL abort_state got busy=%h done=%h want 0 0", busy_o, done_o);
    end
  endtask

  task automatic test_bus();
    exp_d.push_back(32'h0); exp_e.push_back(1'b1);
    rdreg(A_CTRL + 32'h3F);
    ed = exp_d.pop_front(); ee = exp_e.pop_front();
    total++;
    if (rd !== ed || er !== ee || ak !== 1'b0) begin
      bad++; $display("FAIL bus_unmapped got dat=%h err=%b ack=%b want %h %b 0", rd, er, ak, ed, ee);
    end
    @(posedge clk_i); #1;
    total++;
    if (err_o !== 1'b0 || ack_o !== 1'b0) begin
      bad++; $display("FAIL bus_err_pulse got err=%b ack=%b want 0 0", err_o, ack_o);
    end
    exp_d.push_back(32'h0); exp_e.push_back(1'b1);
    rdreg(A_CNT0 + 32'd4);
    ed = exp_d.pop_front(); ee = exp_e.pop_front();
    total++;
    if (rd !== ed || er !== ee) begin
      bad++; $display("FAIL bus_irqmask_off got dat=%h err=%b want %h %b", rd, er, ed, ee);
    end
    bus(A_EDGE, 32'd5, 1'b1, 4'h3);
    total++;
    if (ak !== 1'b1 || er !== 1'b0) begin
      bad++; $display("FAIL bus_partial_ack got ack=%b err=%b want 1 0", ak, er);
    end
    exp_d.push_back(32'd2); rdreg(A_EDGE); ed = exp_d.pop_front();
    total++;
    if (rd !== ed) begin
      bad++; $display("FAIL bus_partial_nowrite got %0d want %0d", rd, ed);
    end
    wr(A_EDGE, 32'd0);
    exp_d.push_back(32'd1); rdreg(A_EDGE); ed = exp_d.pop_front();
    total++;
    if (rd !== ed) begin
      bad++; $display("FAIL bus_edges_zero got %0d want %0d", rd, ed);
    end
    exp_d.push_back(32'h0); rdreg(A_CTRL); ed = exp_d.pop_front();
    total++;
    if (rd !== ed || ak !== 1'b1) begin
      bad++; $display("FAIL bus_ctrl_read got %h ack=%b want %h 1", rd, ak, ed);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_concurrent();
    test_timeout();
    test_restart();
    test_abort();
    test_bus();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no completion want finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/freq_counter_mc.md
Name: freq_counter_mc

Overview:
- Multi-channel reciprocal frequency counter with a Wishbone classic slave register interface.
- Each channel synchronises an external signal into the clk_i domain and counts clk_i cycles across a programmable number of signal rising edges.
- Software computes f = EDGES * f_clk / COUNT.
- Single clock domain, so there is no gated-clock or edge-clocked logic, unlike the previous single-channel counter.

Parameters:
- NUM_CH, 4, number of measured input channels (1..16).
- CNT_W, 32, width of each per-channel reference-cycle counter (16..32).
- EDGE_W, 16, width of the programmable edge-count target.
- SYNC_STAGES, 2, synchroniser flops per input (2..4).
- BASE_ADDR, 32'h8, word address of the CTRL register; all other registers are offsets from it.

Ports:
- clk_i  in  1  system and reference clock.
- ext_rst_i  in  1  asynchronous active-low reset.
- addr_i  in  32  Wishbone word address.
- dat_i  in  32  write data.
- we_i  in  1  write enable.
- sel_i  in  4  byte select; only full-word writes (4'hF) take effect.
- cyc_i  in  1  bus cycle.
- stb_i  in  1  strobe.
- dat_o  out  32  read data.
- ack_o  out  1  acknowledge.
- err_o  out  1  unmapped-address error.
- sig_i  in  NUM_CH  asynchronous signals to be measured.
- busy_o  out  NUM_CH  per-channel measurement in progress.
- done_o  out  NUM_CH  per-channel result valid.

Behaviour:
- Reset: every register, counter and FSM clears; dat_o=0, ack_o=0, err_o=0, busy_o=0, done_o=0; EDGES register resets to 1.
- Register map (word offsets from BASE_ADDR):
  - +0 CTRL: bit k = start channel k (write-1 pulse, reads 0); bit 31 = abort all.
  - +1 STATUS: [15:0] done, [31:16] timeout flags; write-1-to-clear.
  - +2 EDGES: EDGE_W bits; a written value of 0 is stored as 1.
  - +3 TIMEOUT: CNT_W bits; 0 disables the timeout.
  - +4+k: COUNT of channel k, zero-extended.
- Bus: ack_o or err_o asserts exactly 1 cycle after cyc_i&stb_i is sampled high, and deasserts the next cycle (single-cycle pulse per access, no back-to-back ack). Reads are registered. An access to an unmapped offset gives err_o=1, no ack, dat_o=0.
- Input path: SYNC_STAGES-flop synchroniser, then a rising-edge detector (sync & ~sync_d). Total edge latency is SYNC_STAGES+1 cycles.
- Per-channel FSM:
  - IDLE: a start bit for this channel goes to ARM, clears the channel's count and edge counter, and clears its done/timeout flags.
  - ARM: busy=1. A detected edge goes to MEAS; count=1 on that cycle.
  - MEAS: count increments every cycle. Each edge increments the edge counter. When edges==EDGES the FSM goes to DONE on that same cycle; COUNT latches the cycle total (first edge to last edge, inclusive of 1, so exactly period*EDGES).
  - DONE: busy=0, done=1, result held. Start re-arms (the DONE to ARM transition discards the old result).
- Timeout: in ARM or MEAS, if the cycles since start reach TIMEOUT (nonzero), the channel goes to IDLE, the timeout flag is set, COUNT is forced to all-ones, and done stays 0.
- Counter saturation: the count saturates at all-ones and does not wrap; the measurement continues until the edge target or timeout.
- Abort (bit 31), or a start written while a channel is busy: the affected channel returns to IDLE and restarts on the next cycle if start was written; its flags are cleared.
- EDGES/TIMEOUT written mid-measurement: the values are sampled at the start, so the change does not affect the running measurement.
- Simultaneous events:
  - Edge and timeout on the same cycle: edge completion wins.
  - STATUS clear and a new done on the same cycle: set wins.

Optional Feature:
- FREQ_CNT_IRQ_EN defined:
  - Adds port irq_o (out, 1).
  - Adds register +3+NUM_CH+1 IRQ_MASK, NUM_CH bits, reset 0.
  - irq_o = OR over channels of ((done|timeout) & mask), registered, level-sensitive, cleared via STATUS W1C.
- Not defined: no irq_o port and no IRQ_MASK register; that offset returns err_o.

Test Plan:
- Reset: hold ext_rst_i=0 mid-measurement, release -> all outputs 0, EDGES reads 1, COUNT reads 0.
- Single channel: ch0 sig_i period 10 clk, EDGES=4, start ch0 -> done_o[0] rises; COUNT0 reads 40; busy_o[0] is 1 from start until done.
- Concurrent channels: ch1 period 7, ch2 period 13, EDGES=3, start both -> COUNT1=21, COUNT2=39, independent done timing.
- Timeout: TIMEOUT=100, ch3 with no edges -> after 100 cycles STATUS bit 19 set, COUNT3=32'hFFFFFFFF, done_o[3]=0.
- Restart while busy: start ch0 again mid-MEAS -> old partial discarded; new result correct (period 10, EDGES=4 -> 40).
- Bus: read unmapped offset +0x3F -> err_o pulse 1 cycle, ack_o=0; write with sel_i=4'h3 -> register unchanged, ack_o=1.
